// File: rtl/sgx_reset_request.sv
// Reset-request sequencer: merges push-button, PLL lock and software requests into a held,
// lock-qualified areset. Optional software request path enabled by SGX_RESET_SW_REQ_EN.
module sgx_reset_request #(
    parameter int unsigned DEBOUNCE_BITS      = 16,
    parameter int unsigned HOLD_CYCLES        = 64,
    parameter int unsigned LOCK_STABLE_CYCLES = 256
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       button_n,
    input  logic       pll_locked,
    input  logic       sw_reset_req,
    output logic       areset,
    output logic [2:0] reset_cause,
    output logic [7:0] reset_count
);

    localparam int unsigned HoldW = $clog2(HOLD_CYCLES) + 1;
    localparam int unsigned LockW = $clog2(LOCK_STABLE_CYCLES) + 1;
    localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYCLES - 1);
    localparam logic [LockW-1:0] LockLast = LockW'(LOCK_STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        StHold,
        StWaitLock,
        StRun
    } state_e;

    logic                     btn_meta_q, btn_sync_q;
    logic                     lock_meta_q, lock_sync_q;
    logic                     db_pressed_q, db_pressed_d;
    logic [DEBOUNCE_BITS-1:0] db_cnt_q, db_cnt_d;
    state_e                   state_q, state_d;
    logic [HoldW-1:0]         hold_cnt_q, hold_cnt_d;
    logic [LockW-1:0]         lock_cnt_q, lock_cnt_d;
    logic [2:0]               cause_q, cause_d;
    logic [7:0]               count_q, count_d;
    logic                     areset_q, areset_d;
    logic                     sw_eff;
    logic                     lock_lost;

`ifdef SGX_RESET_SW_REQ_EN
    assign sw_eff = sw_reset_req;
`else
    logic unused_sw_reset_req;
    assign unused_sw_reset_req = sw_reset_req;
    assign sw_eff              = 1'b0;
`endif

    assign lock_lost = ~lock_sync_q;

    // Synchronizers idle high so a reset looks like "button released, PLL locked".
    always_ff @(posedge clock) begin
        if (reset) begin
            btn_meta_q  <= 1'b1;
            btn_sync_q  <= 1'b1;
            lock_meta_q <= 1'b1;
            lock_sync_q <= 1'b1;
        end else begin
            btn_meta_q  <= button_n;
            btn_sync_q  <= btn_meta_q;
            lock_meta_q <= pll_locked;
            lock_sync_q <= lock_meta_q;
        end
    end

    always_comb begin
        db_pressed_d = db_pressed_q;
        db_cnt_d     = '0;
        if (~btn_sync_q != db_pressed_q) begin
            if (&db_cnt_q) begin
                db_pressed_d = ~db_pressed_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = '0;
        lock_cnt_d = '0;
        cause_d    = cause_q;
        count_d    = count_q;
        unique case (state_q)
            StHold: begin
                if (db_pressed_q) begin
                    hold_cnt_d = '0;
                end else if (hold_cnt_q == HoldLast) begin
                    state_d = StWaitLock;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            StWaitLock: begin
                // Aborts back to HOLD leave cause/count untouched.
                if (db_pressed_q || sw_eff) begin
                    state_d = StHold;
                end else if (lock_sync_q) begin
                    if (lock_cnt_q == LockLast) begin
                        state_d = StRun;
                    end else begin
                        lock_cnt_d = lock_cnt_q + 1'b1;
                    end
                end
            end
            StRun: begin
                if (db_pressed_q || lock_lost || sw_eff) begin
                    state_d = StHold;
                    cause_d = {sw_eff, lock_lost, db_pressed_q};
                    if (count_q != 8'hFF) begin
                        count_d = count_q + 8'd1;
                    end
                end
            end
            default: state_d = StHold;
        endcase
    end

    assign areset_d = (state_d != StRun);

    always_ff @(posedge clock) begin
        if (reset) begin
            db_pressed_q <= 1'b0;
            db_cnt_q     <= '0;
            state_q      <= StHold;
            hold_cnt_q   <= '0;
            lock_cnt_q   <= '0;
            cause_q      <= 3'b000;
            count_q      <= 8'd0;
            areset_q     <= 1'b1;
        end else begin
            db_pressed_q <= db_pressed_d;
            db_cnt_q     <= db_cnt_d;
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            lock_cnt_q   <= lock_cnt_d;
            cause_q      <= cause_d;
            count_q      <= count_d;
            areset_q     <= areset_d;
        end
    end

    assign areset      = areset_q;
    assign reset_cause = cause_q;
    assign reset_count = count_q;

endmodule

// File: tb/tb_sgx_reset_request.sv
// Bench for sgx_reset_request: vector table, hand sequences, then random traffic
// checked against a behavioural model. Honours SGX_RESET_SW_REQ_EN like the design.
module tb_sgx_reset_request;

    localparam int unsigned DB = 3;
    localparam int unsigned HC = 4;
    localparam int unsigned LC = 8;

`ifdef SGX_RESET_SW_REQ_EN
    localparam bit SwEn = 1'b1;
`else
    localparam bit SwEn = 1'b0;
`endif

    localparam logic [2:0] CauseSw  = SwEn ? 3'b100 : 3'b001;
    localparam logic [7:0] CountSw  = SwEn ? 8'd3 : 8'd2;
    localparam logic [2:0] CauseSim = SwEn ? 3'b110 : 3'b010;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       button_n = 1'b1;
    logic       pll_locked = 1'b1;
    logic       sw_reset_req = 1'b0;
    logic       areset;
    logic [2:0] reset_cause;
    logic [7:0] reset_count;

    always #5 clock = ~clock;

    sgx_reset_request #(
        .DEBOUNCE_BITS     (DB),
        .HOLD_CYCLES       (HC),
        .LOCK_STABLE_CYCLES(LC)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .button_n    (button_n),
        .pll_locked  (pll_locked),
        .sw_reset_req(sw_reset_req),
        .areset      (areset),
        .reset_cause (reset_cause),
        .reset_count (reset_count)
    );

    int unsigned n_cmp = 0;
    int unsigned n_fail = 0;

    // Behavioural model: "running" flag plus elapsed-time tallies rather than a state machine.
    bit         m_b1 = 1, m_b2 = 1, m_l1 = 1, m_l2 = 1;
    bit         m_db = 0;
    int         m_run = 0;
    bit         m_running = 0;
    int         m_elapsed = 0;
    int         m_streak = 0;
    logic [2:0] m_cause = 3'b000;
    int         m_count = 0;

    function automatic void model_edge(input bit r, input bit b, input bit l, input bit s);
        bit pressed, locked, swe;
        if (r) begin
            m_b1 = 1; m_b2 = 1; m_l1 = 1; m_l2 = 1;
            m_db = 0; m_run = 0; m_running = 0; m_elapsed = 0; m_streak = 0;
            m_cause = 3'b000; m_count = 0;
            return;
        end
        pressed = m_db;
        locked  = m_l2;
        swe     = s && SwEn;
        if (m_running) begin
            if (pressed || !locked || swe) begin
                m_running = 0; m_elapsed = 0; m_streak = 0;
                m_cause = {swe, !locked, pressed};
                m_count = (m_count < 255) ? m_count + 1 : 255;
            end
        end else if (m_elapsed < int'(HC)) begin
            m_elapsed = pressed ? 0 : m_elapsed + 1;
            m_streak  = 0;
        end else begin
            if (pressed || swe) begin
                m_elapsed = 0; m_streak = 0;
            end else if (!locked) begin
                m_streak = 0;
            end else if (m_streak + 1 >= int'(LC)) begin
                m_running = 1; m_streak = 0;
            end else begin
                m_streak++;
            end
        end
        if ((!m_b2) != m_db) begin
            if (m_run == (1 << DB) - 1) begin
                m_db = !m_db; m_run = 0;
            end else begin
                m_run++;
            end
        end else begin
            m_run = 0;
        end
        m_b2 = m_b1; m_b1 = b;
        m_l2 = m_l1; m_l1 = l;
    endfunction

    task automatic tick(input bit r, input bit b, input bit l, input bit s);
        reset = r; button_n = b; pll_locked = l; sw_reset_req = s;
        @(posedge clock);
        model_edge(r, b, l, s);
        @(negedge clock);
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_areset(input logic val, input int budget, input string name);
        int i;
        for (i = 0; i < budget && areset !== val; i++) tick(0, 1, 1, 0);
        n_cmp++;
        if (areset !== val) begin
            n_fail++;
            $display("FAIL %s: areset stuck at %b, expected %b within %0d cycles",
                     name, areset, val, budget);
        end
    endtask

    typedef struct {
        int unsigned cycles;
        bit          rst, btn_n, lock, sw;
        logic        exp_areset;
        logic [2:0]  exp_cause;
        logic [7:0]  exp_count;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input int unsigned n, input bit r, input bit b, input bit l,
                                input bit s, input logic a, input logic [2:0] c,
                                input logic [7:0] k);
        vec_t v;
        v.cycles = n; v.rst = r; v.btn_n = b; v.lock = l; v.sw = s;
        v.exp_areset = a; v.exp_cause = c; v.exp_count = k;
        vecs.push_back(v);
    endfunction

    initial begin
        // Power-up: release lands exactly HC+LC edges after reset drops.
        add(3,  1, 1, 1, 0, 1, 3'b000, 8'd0);
        add(11, 0, 1, 1, 0, 1, 3'b000, 8'd0);
        add(1,  0, 1, 1, 0, 0, 3'b000, 8'd0);
        // One-cycle lock drop in RUN, then a second drop 5 cycles into WAIT_LOCK.
        add(1,  0, 1, 0, 0, 0, 3'b000, 8'd0);
        add(1,  0, 1, 1, 0, 0, 3'b000, 8'd0);
        add(1,  0, 1, 1, 0, 1, 3'b010, 8'd1);
        add(9,  0, 1, 1, 0, 1, 3'b010, 8'd1);
        add(1,  0, 1, 0, 0, 1, 3'b010, 8'd1);
        add(1,  0, 1, 1, 0, 1, 3'b010, 8'd1);
        add(8,  0, 1, 1, 0, 1, 3'b010, 8'd1);
        add(1,  0, 1, 1, 0, 0, 3'b010, 8'd1);
        // Button: short glitch ignored, then a 20-cycle press.
        add(5,  0, 0, 1, 0, 0, 3'b010, 8'd1);
        add(20, 0, 1, 1, 0, 0, 3'b010, 8'd1);
        add(10, 0, 0, 1, 0, 0, 3'b010, 8'd1);
        add(1,  0, 0, 1, 0, 1, 3'b001, 8'd2);
        add(9,  0, 0, 1, 0, 1, 3'b001, 8'd2);
        add(21, 0, 1, 1, 0, 1, 3'b001, 8'd2);
        add(1,  0, 1, 1, 0, 0, 3'b001, 8'd2);
        // Software pulse.
        add(1,  0, 1, 1, 1, SwEn, CauseSw, CountSw);
        add(11, 0, 1, 1, 0, SwEn, CauseSw, CountSw);
        add(1,  0, 1, 1, 0, 0, CauseSw, CountSw);
        // Lock loss and software pulse reach the FSM together.
        add(1,  0, 1, 0, 0, 0, CauseSw, CountSw);
        add(1,  0, 1, 1, 0, 0, CauseSw, CountSw);
        add(1,  0, 1, 1, 1, 1, CauseSim, CountSw + 8'd1);
        add(11, 0, 1, 1, 0, 1, CauseSim, CountSw + 8'd1);
        add(1,  0, 1, 1, 0, 0, CauseSim, CountSw + 8'd1);

        for (int i = 0; i < vecs.size(); i++) begin
            for (int c = 0; c < int'(vecs[i].cycles); c++) begin
                tick(vecs[i].rst, vecs[i].btn_n, vecs[i].lock, vecs[i].sw);
            end
            check($sformatf("row%0d_areset", i), {7'd0, areset}, {7'd0, vecs[i].exp_areset});
            check($sformatf("row%0d_cause", i), {5'd0, reset_cause}, {5'd0, vecs[i].exp_cause});
            check($sformatf("row%0d_count", i), reset_count, vecs[i].exp_count);
        end

        // Saturation: 300 more resets (software if enabled, otherwise lock loss).
        for (int i = 0; i < 300; i++) begin
            if (SwEn) tick(0, 1, 1, 1);
            else tick(0, 1, 0, 0);
            wait_areset(1'b1, 6, "sat_assert");
            wait_areset(1'b0, 30, "sat_release");
        end
        check("sat_count", reset_count, 8'd255);
        check("sat_cause", {5'd0, reset_cause}, {5'd0, SwEn ? 3'b100 : 3'b010});

        // Reset asserted while in WAIT_LOCK.
        if (SwEn) tick(0, 1, 1, 1);
        else tick(0, 1, 0, 0);
        wait_areset(1'b1, 6, "wl_enter");
        repeat (HC + 1) tick(0, 1, 1, 0);
        check("wl_areset", {7'd0, areset}, 8'd1);
        check("wl_count_pre", reset_count, 8'd255);
        tick(1, 1, 1, 0);
        check("wl_rst_areset", {7'd0, areset}, 8'd1);
        check("wl_rst_cause", {5'd0, reset_cause}, 8'd0);
        check("wl_rst_count", reset_count, 8'd0);
        repeat (HC + LC - 1) tick(0, 1, 1, 0);
        check("wl_still_held", {7'd0, areset}, 8'd1);
        tick(0, 1, 1, 0);
        check("wl_release", {7'd0, areset}, 8'd0);

        // Random traffic against the model.
        begin
            int press_left = 0;
            bit b, l, s, r;
            tick(1, 1, 1, 0);
            tick(1, 1, 1, 0);
            for (int i = 0; i < 5000; i++) begin
                if (press_left == 0 && $urandom_range(0, 99) < 2) press_left = $urandom_range(1, 20);
                b = (press_left == 0);
                if (press_left > 0) press_left--;
                l = ($urandom_range(0, 99) >= 2);
                s = ($urandom_range(0, 99) < 2);
                r = ($urandom_range(0, 999) < 3);
                tick(r, b, l, s);
                check("rand_areset", {7'd0, areset}, {7'd0, ~m_running});
                check("rand_cause", {5'd0, reset_cause}, {5'd0, m_cause});
                check("rand_count", reset_count, m_count[7:0]);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/sgx_reset_request.md
# sgx_reset_request

Reset-request sequencer that sits directly upstream of the SGX multi-domain reset tree. It produces the `areset` that the tree consumes. It runs on a free-running reference clock and merges three reset sources: a board push-button, PLL lock, and a software request. It holds `areset` high for a guaranteed minimum and releases it only after the PLL has stayed locked for a qualified interval. It also records the cause of the most recent reset and counts resets.

## Interface
- `DEBOUNCE_BITS`, default 16: the button level must be stable for 2^DEBOUNCE_BITS synchronized cycles before it is accepted.
- `HOLD_CYCLES`, default 64: minimum number of cycles spent in HOLD; must be ≥1.
- `LOCK_STABLE_CYCLES`, default 256: number of consecutive synchronized cycles `pll_locked` must stay high before release; must be ≥1.
- `clock` input 1: free-running reference clock, not derived from any PLL.
- `reset` input 1: one clock; reset is synchronous and active-high.
- `button_n` input 1: asynchronous push-button, active-low.
- `pll_locked` input 1: asynchronous PLL lock indication.
- `sw_reset_req` input 1: single-cycle request pulse, synchronous to `clock`.
- `areset` output 1: reset request to the downstream reset tree; registered.
- `reset_cause` output 3: sticky cause of the last RUN→HOLD transition. Bit0 = button, bit1 = lock loss, bit2 = software.
- `reset_count` output 8: number of RUN→HOLD transitions, saturating at 255.

## Operation
- `button_n` and `pll_locked` each pass through a 2-flop synchronizer. The synchronizer flops reset to 1.
- Button debounce:
  - Debounced state resets to "released".
  - A DEBOUNCE_BITS-wide counter increments every cycle the synchronized level differs from the debounced state, and clears whenever they match.
  - On the cycle the counter is all-ones and the mismatch is still present, the debounced state flips and the counter clears.
- FSM states: HOLD, WAIT_LOCK, RUN. `areset` is 1 in HOLD and WAIT_LOCK, and 0 in RUN.
- HOLD:
  - A hold counter increments from 0.
  - The counter is held at 0 while the debounced button is pressed.
  - The FSM moves to WAIT_LOCK on the cycle the counter equals HOLD_CYCLES-1.
- WAIT_LOCK:
  - A lock counter increments while synchronized lock is 1 and clears while it is 0.
  - The FSM moves to RUN when the counter equals LOCK_STABLE_CYCLES-1 with lock still 1.
  - A debounced press or an effective `sw_reset_req` sends the FSM to HOLD. The cause and count registers are not updated.
- RUN: the triggers are debounced press, synchronized lock = 0, and effective `sw_reset_req`. Any trigger causes:
  - next state HOLD with the counters cleared;
  - `reset_cause` loaded with every trigger active in that cycle (not OR-ed with the old value);
  - `reset_count` incremented, saturating at 255.
- A trigger always takes priority over a same-cycle completion of HOLD or WAIT_LOCK.
- Counter widths are $clog2(param)+1 bits, so they never wrap.

## Timing
- Values while `reset` is asserted and on the first cycle after:
  - state HOLD, `areset` 1, all counters 0;
  - `reset_cause` 3'b000, `reset_count` 0;
  - debounced button "released".
- Asserting `reset` mid-operation returns the block to this state on the next edge, from any state.
- Release latency after `reset` falls, with lock already high and button released: `areset` falls exactly HOLD_CYCLES+LOCK_STABLE_CYCLES cycles later.
- Lock loss in RUN: `areset` rises 3 edges after the `pll_locked` fall is sampled (2 synchronizer edges + 1 register edge). A 1-cycle low pulse is enough.
- Software request in RUN: `areset` is high on the edge after the pulse.
- Button press: `areset` rises 2 + 2^DEBOUNCE_BITS + 1 cycles after the low level is first sampled.
- `areset` is glitch-free; it is driven directly from a flop.

## Configuration
- Macro `SGX_RESET_SW_REQ_EN`.
- Defined: `sw_reset_req` behaves as described above.
- Undefined:
  - the `sw_reset_req` port remains but is ignored;
  - `reset_cause[2]` is constant 0;
  - the rest of the behaviour is unchanged.

## Test plan
All scenarios use DEBOUNCE_BITS=3, HOLD_CYCLES=4, LOCK_STABLE_CYCLES=8.
- Power-up: hold `reset` high for 3 cycles with lock=1 and button_n=1 → `areset` falls exactly 12 cycles after `reset` falls; `reset_cause` 0; `reset_count` 0.
- Lock flicker:
  - In RUN, drive `pll_locked` low for 1 cycle → `areset` rises 3 edges later; `reset_cause` 3'b010; `reset_count` 1.
  - Drop lock again 5 cycles into WAIT_LOCK → the lock counter restarts, and `areset` falls 8 cycles after lock is synchronously high again.
- Button:
  - A 5-cycle low glitch → no reset.
  - Holding low for 20 cycles → `reset_cause` 3'b001, and the FSM stays in HOLD while pressed.
  - `areset` falls 12 cycles after the debounced release.
- Software request:
  - With the macro defined, a pulse in RUN → `areset` high next edge; `reset_cause` 3'b100.
  - With the macro undefined → no effect.
- Simultaneous triggers: lock loss and the `sw_reset_req` pulse reach the FSM in the same cycle → `reset_cause` 3'b110; `reset_count` increments by 1.
- Saturation and reset:
  - 300 software-triggered resets → `reset_count` 255.
  - Asserting `reset` in WAIT_LOCK → next edge gives HOLD, `reset_count` 0, `reset_cause` 0.
